// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int unsigned Width = 8
);
  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             br_in;
  logic             busy;
  logic             done;
  logic [Width-1:0] dif;
  logic             br_out;

  modport master (
    output start, a, b, br_in,
    input  busy, done, dif, br_out
  );

  modport slave (
    input  start, a, b, br_in,
    output busy, done, dif, br_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell fed LSB first.
// Borrow is carried in a flip-flop; the result appears after Width cycles.
module serial_subtractor #(
  parameter int unsigned Width = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_subtractor_if.slave  bus_io
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q;
  logic [Width-1:0] sa_q, sb_q, part_q, dif_q;
  logic [CntW-1:0]  cnt_q;
  logic             br_q, br_out_q, busy_q, done_q;
  logic             diff_bit, br_d;

  // Full-subtractor cell on the current LSB pair.
  always_comb begin
    diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      part_q   <= '0;
      dif_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      br_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          if (bus_io.start) begin
            state_q <= StRun;
            sa_q    <= bus_io.a;
            sb_q    <= bus_io.b;
            br_q    <= bus_io.br_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          sa_q   <= {1'b0, sa_q[Width-1:1]};
          sb_q   <= {1'b0, sb_q[Width-1:1]};
          part_q <= {diff_bit, part_q[Width-1:1]};
          br_q   <= br_d;
          if (cnt_q == CntLast) begin
            state_q  <= StFin;
            dif_q    <= {diff_bit, part_q[Width-1:1]};
            br_out_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.busy   = busy_q;
  assign bus_io.done   = done_q;
  assign bus_io.dif    = dif_q;
  assign bus_io.br_out = br_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for scenarios,
// a 4-bit instance for the full operand sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.Width(8)) bus8 ();
  serial_subtractor_if #(.Width(4)) bus4 ();

  serial_subtractor #(.Width(8)) u_dut8 (.clk_i(clk), .rst_i(rst), .bus_io(bus8.slave));
  serial_subtractor #(.Width(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus_io(bus4.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse START for one cycle, then wait (bounded) for DONE.
  // lat = cycles from the START cycle to the DONE cycle, -1 on timeout.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int nbusy, output int overlap);
    lat = -1; nbusy = 0; overlap = 0;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.br_in = bin;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus8.start = 1'b0;
      if (bus8.busy) nbusy++;
      if (bus8.busy && bus8.done) overlap++;
      if (bus8.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.br_in = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.br_in = 1'b0;
    #12;
    tests_run++;
    if ({bus8.busy, bus8.done, bus8.br_out} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b want 000", {bus8.busy, bus8.done, bus8.br_out});
    end
    tests_run++;
    if (bus8.dif !== 8'h00) begin
      fails++; $display("FAIL reset_dif got %h want 00", bus8.dif);
    end
    tests_run++;
    if ({bus4.busy, bus4.done, bus4.br_out, bus4.dif} !== 7'b0) begin
      fails++; $display("FAIL reset_w4 got %b want 0", {bus4.busy, bus4.done, bus4.br_out, bus4.dif});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, nbusy, ov;
    do_op8(8'h5A, 8'h3C, 1'b0, lat, nbusy, ov);
    tests_run++;
    if (lat !== 9) begin fails++; $display("FAIL basic_latency got %0d want 9", lat); end
    tests_run++;
    if (nbusy !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d want 8", nbusy); end
    tests_run++;
    if (ov !== 0) begin fails++; $display("FAIL basic_busy_done_overlap got %0d want 0", ov); end
    tests_run++;
    if (bus8.dif !== 8'h1E) begin fails++; $display("FAIL basic_dif got %h want 1e", bus8.dif); end
    tests_run++;
    if (bus8.br_out !== 1'b0) begin fails++; $display("FAIL basic_br got %b want 0", bus8.br_out); end
    tick();
  endtask

  task automatic test_underflow();
    logic [7:0] va [3] = '{8'h00, 8'h10, 8'hFF};
    logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h00};
    logic       vi [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ed [3] = '{8'hFF, 8'hFF, 8'hFE};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    int lat, nbusy, ov;
    for (int i = 0; i < 3; i++) begin
      do_op8(va[i], vb[i], vi[i], lat, nbusy, ov);
      tests_run++;
      if (lat !== 9 || bus8.dif !== ed[i] || bus8.br_out !== eb[i]) begin
        fails++;
        $display("FAIL underflow_%0d got lat=%0d dif=%h br=%b want lat=9 dif=%h br=%b",
                 i, lat, bus8.dif, bus8.br_out, ed[i], eb[i]);
      end
      tick();
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] model;
    logic [3:0] prev_dif = 4'h0;
    int lat;
    for (int i = 0; i < 512; i++) begin
      model = {1'b0, 4'(i)} - {1'b0, 4'(i >> 4)} - 5'(i >> 8);
      bus4.start = 1'b1; bus4.a = 4'(i); bus4.b = 4'(i >> 4); bus4.br_in = 1'(i >> 8);
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        tick();
        bus4.start = 1'b0;
        if (bus4.done) begin
          lat = c;
          break;
        end
        tests_run++;
        if (bus4.dif !== prev_dif) begin
          fails++; $display("FAIL exh_stable_%0d got %h want %h", i, bus4.dif, prev_dif);
        end
      end
      tests_run++;
      if (lat !== 5 || bus4.dif !== model[3:0] || bus4.br_out !== model[4]) begin
        fails++;
        $display("FAIL exh_%0d got lat=%0d dif=%h br=%b want lat=5 dif=%h br=%b",
                 i, lat, bus4.dif, bus4.br_out, model[3:0], model[4]);
      end
      prev_dif = model[3:0];
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int ndone = 0, done_cyc = -1;
    for (int c = 0; c < 25; c++) begin
      bus8.start = (c == 0 || c == 3);
      bus8.a = (c == 3) ? 8'h00 : 8'h80;
      bus8.b = 8'h01; bus8.br_in = 1'b0;
      tick();
      if (bus8.done) begin
        ndone++;
        done_cyc = c + 1;
        tests_run++;
        if (bus8.dif !== 8'h7F || bus8.br_out !== 1'b0) begin
          fails++; $display("FAIL busy_ignore_result got %h/%b want 7f/0", bus8.dif, bus8.br_out);
        end
      end
    end
    tests_run++;
    if (ndone !== 1 || done_cyc !== 9) begin
      fails++; $display("FAIL busy_ignore_done got n=%0d at %0d want n=1 at 9", ndone, done_cyc);
    end
    tests_run++;
    if (bus8.busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_idle got %b want 0", bus8.busy); end
  endtask

  task automatic test_back_to_back();
    int         nd = 0;
    int         cyc [2] = '{-1, -1};
    logic [7:0] dv [2];
    logic       bv [2];
    for (int c = 0; c < 22; c++) begin
      bus8.start = (c <= 9);
      bus8.a = (c == 0) ? 8'h05 : 8'h03;
      bus8.b = (c == 0) ? 8'h03 : 8'h05;
      bus8.br_in = 1'b0;
      tick();
      if (bus8.done && nd < 2) begin
        cyc[nd] = c + 1; dv[nd] = bus8.dif; bv[nd] = bus8.br_out; nd++;
      end
    end
    tests_run++;
    if (nd !== 2 || cyc[0] !== 9 || cyc[1] !== 18) begin
      fails++; $display("FAIL b2b_done_cycles got n=%0d %0d,%0d want 9,18", nd, cyc[0], cyc[1]);
    end
    tests_run++;
    if (dv[0] !== 8'h02 || bv[0] !== 1'b0) begin
      fails++; $display("FAIL b2b_first got %h/%b want 02/0", dv[0], bv[0]);
    end
    tests_run++;
    if (dv[1] !== 8'hFE || bv[1] !== 1'b1) begin
      fails++; $display("FAIL b2b_second got %h/%b want fe/1", dv[1], bv[1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nbusy, ov, ndone = 0;
    do_op8(8'h5A, 8'h3C, 1'b0, lat, nbusy, ov);
    tests_run++;
    if (bus8.dif !== 8'h1E) begin fails++; $display("FAIL rstmid_pre got %h want 1e", bus8.dif); end
    tick();
    bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h01; bus8.br_in = 1'b0;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus8.busy, bus8.done, bus8.br_out, bus8.dif} !== 11'b0) begin
      fails++;
      $display("FAIL rstmid_outputs got busy=%b done=%b br=%b dif=%h want all 0",
               bus8.busy, bus8.done, bus8.br_out, bus8.dif);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus8.done) ndone++;
    end
    tests_run++;
    if (ndone !== 0 || bus8.dif !== 8'h00) begin
      fails++; $display("FAIL rstmid_no_done got n=%0d dif=%h want 0/00", ndone, bus8.dif);
    end
    do_op8(8'h00, 8'h01, 1'b0, lat, nbusy, ov);
    tests_run++;
    if (lat !== 9 || bus8.dif !== 8'hFF || bus8.br_out !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_after got lat=%0d %h/%b want 9 ff/1", lat, bus8.dif, bus8.br_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_exhaustive();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor. It is the sequential stage wrapped around the one-bit FULLSUBTRACTOR cell: it feeds that cell one operand bit pair per clock, LSB first, and keeps the borrow in a flip-flop between bits. It consumes two WIDTH-bit operands plus a borrow-in, and produces a WIDTH-bit difference and a borrow-out after WIDTH cycles. It trades latency for area in datapaths where a parallel ripple subtractor is too large.

## Interface
- WIDTH, default 8, operand and result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock. One clock domain only.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only when the block can accept (see Operation).
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- BR_IN  input  1  initial borrow; sampled on the accepting edge only.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when DIF and BR_OUT are updated.
- DIF  output  WIDTH  result register, (A - B - BR_IN) mod 2^WIDTH.
- BR_OUT  output  1  final borrow: 1 when A < B + BR_IN (unsigned).

## Operation
- States:
  - IDLE: waiting for START.
  - RUN: shifting bits through the cell.
  - FIN: result written, DONE high.
- IDLE -> RUN when START=1 at a clock edge. On that edge:
  - A and B load into shift registers SA and SB.
  - The borrow flip-flop loads BR_IN.
  - The bit counter clears to 0.
- RUN, each edge:
  - Compute d = SA[0]^SB[0]^br and nb = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&br).
  - Shift SA and SB right by one.
  - Shift d into the MSB of an internal partial-result register.
  - Set br = nb and increment the counter.
- RUN -> FIN on the edge that processes bit WIDTH-1 (counter = WIDTH-1). On that edge:
  - DIF loads the completed partial result, including the bit d just computed.
  - BR_OUT loads the final nb.
- FIN lasts exactly one cycle.
  - FIN -> RUN if START=1 (back-to-back accept, same load actions as from IDLE).
  - FIN -> IDLE otherwise.
- START is ignored while in RUN. Operand changes during RUN have no effect.
- DIF and BR_OUT change only on the RUN->FIN edge. They hold their value through IDLE and through the next operation until that operation completes.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1 in RUN.

## Timing
- Reset, asynchronous, takes effect immediately:
  - State = IDLE.
  - BUSY=0, DONE=0, DIF=0, BR_OUT=0.
  - Shift registers, borrow flip-flop and counter = 0.
- Reset during RUN or FIN aborts the operation. No DONE is produced and DIF is not updated with a partial value.
- After RST deasserts, START is accepted on the first rising edge.
- Latency. START is high in cycle 0 and sampled at edge 0.
  - BUSY is high in cycles 1..WIDTH.
  - DONE=1 and BUSY=0 in cycle WIDTH+1, and DIF/BR_OUT are valid in that cycle.
- Throughput: one result per WIDTH+1 cycles with START held high or re-asserted during FIN.
- BUSY and DONE are never high in the same cycle. Both are registered outputs decoded from the state.
- No combinational path from any input to any output.

## Test plan
- Basic subtract, WIDTH=8: A=0x5A, B=0x3C, BR_IN=0, START pulse.
  - DONE exactly 9 cycles after the START cycle.
  - DIF=0x1E, BR_OUT=0. BUSY high for 8 cycles.
- Underflow and borrow-in, WIDTH=8:
  - A=0x00, B=0x01, BR_IN=0 -> DIF=0xFF, BR_OUT=1.
  - A=0x10, B=0x10, BR_IN=1 -> DIF=0xFF, BR_OUT=1.
  - A=0xFF, B=0x00, BR_IN=1 -> DIF=0xFE, BR_OUT=0.
- Exhaustive, WIDTH=4: all 512 (A, B, BR_IN) combinations against the arithmetic model. Every DIF/BR_OUT matches, and DIF is stable between DONE pulses.
- START and operand changes while BUSY:
  - Start A=0x80, B=0x01. Pulse START=1 with A=0x00 in cycle 3.
  - Result is DIF=0x7F, BR_OUT=0. Exactly one DONE. The block returns to IDLE.
- Back-to-back, WIDTH=8: hold START=1 continuously with A=0x05, B=0x03, then A=0x03, B=0x05 after the first accept.
  - DONE in cycles 9 and 18.
  - DIF=0x02/BR_OUT=0, then DIF=0xFE/BR_OUT=1.
- Reset mid-operation:
  - Complete 0x5A-0x3C first (DIF=0x1E). Then start 0x00-0x01 and assert RST in cycle 4.
  - Immediately all outputs = 0, and no DONE follows.
  - A new START after release completes normally.
